// File: rtl/bg_sdram_sched.sv
// Background picture SDRAM channel scheduler: pairs download bytes into 16-bit writes
// and keeps a small 32-bit RGBA prefetch FIFO filled ahead of the pixel stream.
module bg_sdram_sched #(
    parameter int DEPTH     = 4,
    parameter int ADDR_STEP = 2
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_sdram_ok,
    input  logic        i_dl_active,
    input  logic        i_dl_wr,
    input  logic [24:0] i_dl_addr,
    input  logic [7:0]  i_dl_data,
    input  logic        i_ce_pix,
    input  logic        i_hblank,
    input  logic        i_vblank,
    input  logic        i_vs,
    output logic [23:0] o_ch_addr,
    output logic [15:0] o_ch_din,
    output logic        o_ch_req,
    output logic        o_ch_rnw,
    input  logic        i_ch_ready,
    input  logic [31:0] i_ch_dout,
    output logic [31:0] o_bg_rgba,
    output logic        o_use_bg,
    output logic        o_underrun,
    output logic        o_wr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FILL_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic        r_dl_prev;
    logic        r_vs_prev;
    logic        r_use_bg;
    logic        r_underrun;
    logic        r_wr_ovf;
    logic [7:0]  r_even_byte;
    logic        r_wb_valid;
    logic [23:0] r_wb_addr;
    logic [15:0] r_wb_data;
    logic [23:0] r_rd_addr;
    logic        r_stale;
    logic [31:0] r_bg_rgba;

    logic [31:0]   r_fifo_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_fill;

    logic w_issue_wr;
    logic w_issue_rd;
    logic w_rd_done;
    logic w_dl_rise;
    logic w_dl_fall;
    logic w_frame;
    logic w_pop_slot;
    logic w_fifo_empty;
    logic w_push;
    logic w_pop;
    logic w_word_in;

    assign w_dl_rise    = i_dl_active & ~r_dl_prev;
    assign w_dl_fall    = ~i_dl_active & r_dl_prev;
    assign w_frame      = i_ce_pix & i_vs & ~r_vs_prev;
    assign w_pop_slot   = i_ce_pix & ~(i_hblank | i_vblank) & r_use_bg;
    assign w_fifo_empty = (r_fill == '0);
    // The frame-restart flush overrides any push or pop landing in the same cycle.
    assign w_push       = w_rd_done & ~r_stale & ~w_frame;
    assign w_pop        = w_pop_slot & ~w_fifo_empty & ~w_frame;
    assign w_word_in    = i_dl_wr & i_dl_addr[0];

    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Only one request is ever outstanding, so in IDLE the FIFO fill alone bounds new reads.
    always_comb begin
        w_state_next = r_state;
        w_issue_wr   = 1'b0;
        w_issue_rd   = 1'b0;
        w_rd_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_wb_valid) begin
                    w_issue_wr   = 1'b1;
                    w_state_next = ST_WR_WAIT;
                end else if (r_use_bg && !i_dl_active && (r_fill < FILL_MAX)) begin
                    w_issue_rd   = 1'b1;
                    w_state_next = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (i_ch_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (i_ch_ready) begin
                    w_rd_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_ch_req  = w_issue_wr | w_issue_rd;
    assign o_ch_rnw  = w_issue_rd;
    assign o_ch_addr = w_issue_wr ? r_wb_addr : r_rd_addr;
    assign o_ch_din  = r_wb_data;

    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_dl_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_use_bg  <= 1'b0;
        end else begin
            r_dl_prev <= i_dl_active;
            if (i_ce_pix) begin
                r_vs_prev <= i_vs;
            end
            if (w_dl_rise) begin
                r_use_bg <= 1'b0;
            end else if (w_dl_fall && i_sdram_ok) begin
                r_use_bg <= 1'b1;
            end
        end
    end

    // A new word may reuse the buffer in the very cycle its predecessor is issued.
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_even_byte <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_wr_ovf    <= 1'b0;
        end else begin
            if (i_dl_wr && !i_dl_addr[0]) begin
                r_even_byte <= i_dl_data;
            end
            if (w_word_in) begin
                if (r_wb_valid && !w_issue_wr) begin
                    r_wr_ovf <= 1'b1;
                end else begin
                    r_wb_valid <= 1'b1;
                    r_wb_addr  <= i_dl_addr[24:1];
                    r_wb_data  <= {i_dl_data, r_even_byte};
                end
            end else if (w_issue_wr) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    // A read in flight across a frame restart (or issued in that same cycle) belongs to
    // the old frame: its data is discarded and it does not advance the read address.
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_rd_addr <= '0;
            r_stale   <= 1'b0;
        end else begin
            if (w_frame && ((r_state == ST_RD_WAIT && !i_ch_ready) || w_issue_rd)) begin
                r_stale <= 1'b1;
            end else if (w_rd_done) begin
                r_stale <= 1'b0;
            end
            if (w_frame) begin
                r_rd_addr <= '0;
            end else if (w_rd_done && !r_stale) begin
                r_rd_addr <= r_rd_addr + 24'(ADDR_STEP);
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (w_push) begin
            r_fifo_mem[r_wptr] <= i_ch_dout;
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else if (w_frame) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_bg_rgba  <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (!r_use_bg) begin
                r_bg_rgba <= '0;
            end else if (w_pop_slot) begin
                r_bg_rgba <= w_fifo_empty ? 32'h0 : r_fifo_mem[r_rptr];
            end
            if (w_frame) begin
                r_underrun <= 1'b0;
            end else if (w_pop_slot && w_fifo_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign o_bg_rgba  = r_bg_rgba;
    assign o_use_bg   = r_use_bg;
    assign o_underrun = r_underrun;
    assign o_wr_ovf   = r_wr_ovf;

endmodule

// File: tb/tb_bg_sdram_sched.sv
// Directed bench for bg_sdram_sched: download writes, prefetch reads, pixel pops,
// underrun, frame restart with a stale read, write overflow and mid-request reset.
module tb_bg_sdram_sched;

    logic        clk;
    logic        rst;
    logic        sdram_ok;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        ce_pix;
    logic        hblank;
    logic        vblank;
    logic        vs;
    logic [23:0] ch_addr;
    logic [15:0] ch_din;
    logic        ch_req;
    logic        ch_rnw;
    logic        ch_ready;
    logic [31:0] ch_dout;
    logic [31:0] bg_rgba;
    logic        use_bg;
    logic        underrun;
    logic        wr_ovf;

    int n_checks = 0;
    int n_errors = 0;

    bg_sdram_sched #(.DEPTH(4), .ADDR_STEP(2)) dut (
        .i_clk_sys  (clk),
        .i_reset    (rst),
        .i_sdram_ok (sdram_ok),
        .i_dl_active(dl_active),
        .i_dl_wr    (dl_wr),
        .i_dl_addr  (dl_addr),
        .i_dl_data  (dl_data),
        .i_ce_pix   (ce_pix),
        .i_hblank   (hblank),
        .i_vblank   (vblank),
        .i_vs       (vs),
        .o_ch_addr  (ch_addr),
        .o_ch_din   (ch_din),
        .o_ch_req   (ch_req),
        .o_ch_rnw   (ch_rnw),
        .i_ch_ready (ch_ready),
        .i_ch_dout  (ch_dout),
        .o_bg_rgba  (bg_rgba),
        .o_use_bg   (use_bg),
        .o_underrun (underrun),
        .o_wr_ovf   (wr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int cnt = 0;
        while (ch_req !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk(tag, {31'd0, ch_req}, 32'd1);
    endtask

    task automatic ready_pulse(input logic [31:0] data);
        ch_ready = 1'b1;
        ch_dout  = data;
        tick();
        ch_ready = 1'b0;
        ch_dout  = '0;
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},  {31'd0, ch_req},   32'd0);
        chk({tag, "_addr"}, {8'd0, ch_addr},   32'd0);
        chk({tag, "_din"},  {16'd0, ch_din},   32'd0);
        chk({tag, "_bg"},   bg_rgba,           32'd0);
        chk({tag, "_use"},  {31'd0, use_bg},   32'd0);
        chk({tag, "_und"},  {31'd0, underrun}, 32'd0);
        chk({tag, "_ovf"},  {31'd0, wr_ovf},   32'd0);
    endtask

    initial begin
        rst = 1'b1; sdram_ok = 1'b1; dl_active = 1'b0; dl_wr = 1'b0;
        dl_addr = '0; dl_data = '0; ce_pix = 1'b0; hblank = 1'b0;
        vblank = 1'b0; vs = 1'b0; ch_ready = 1'b0; ch_dout = '0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk_all_zero("post_reset");

        // 1: download one word, then finish the download
        dl_active = 1'b1;
        tick();
        dl_byte(25'h0, 8'h11);
        dl_byte(25'h1, 8'h22);
        chk("t1_req", {31'd0, ch_req}, 32'd1);
        chk("t1_rnw", {31'd0, ch_rnw}, 32'd0);
        chk("t1_addr", {8'd0, ch_addr}, 32'h0);
        chk("t1_din", {16'd0, ch_din}, 32'h2211);
        tick(); tick();
        ready_pulse(32'h0);
        chk("t1_use_before", {31'd0, use_bg}, 32'd0);
        dl_active = 1'b0;
        tick();
        chk("t1_use_bg", {31'd0, use_bg}, 32'd1);

        // 2: four prefetch reads fill the FIFO, then four pops
        for (int n = 0; n < 4; n++) begin
            wait_req($sformatf("t2_req%0d", n));
            chk($sformatf("t2_rnw%0d", n), {31'd0, ch_rnw}, 32'd1);
            chk($sformatf("t2_addr%0d", n), {8'd0, ch_addr}, 32'(2 * n));
            tick(); tick(); tick();
            ready_pulse(32'hA000_0000 + 32'(n));
        end
        chk("t2_full_noreq", {31'd0, ch_req}, 32'd0);
        ce_pix = 1'b1;
        tick();
        chk("t2_pop0", bg_rgba, 32'hA000_0000);
        chk("t2_refill_req", {31'd0, ch_req}, 32'd1);
        chk("t2_refill_addr", {8'd0, ch_addr}, 32'h8);
        for (int n = 1; n < 4; n++) begin
            tick();
            chk($sformatf("t2_pop%0d", n), bg_rgba, 32'hA000_0000 + 32'(n));
        end
        chk("t2_no_underrun", {31'd0, underrun}, 32'd0);
        ce_pix = 1'b0;

        // 3: read at 8 stalls, pixel pops an empty FIFO
        ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
        chk("t3_bg_zero", bg_rgba, 32'h0);
        chk("t3_underrun", {31'd0, underrun}, 32'd1);
        repeat (200) tick();
        ready_pulse(32'hB000_0000);
        chk("t3_next_req", {31'd0, ch_req}, 32'd1);
        chk("t3_next_addr", {8'd0, ch_addr}, 32'hA);
        tick();
        vs = 1'b1; vblank = 1'b1; ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
        chk("t3_underrun_clr", {31'd0, underrun}, 32'd0);
        chk("t3_rdaddr_zero", {8'd0, ch_addr}, 32'h0);
        chk("t3_busy_noreq", {31'd0, ch_req}, 32'd0);

        // 4: stale read completes, not pushed; next read restarts at 0
        ready_pulse(32'hDEAD_BEEF);
        chk("t4_req", {31'd0, ch_req}, 32'd1);
        chk("t4_addr", {8'd0, ch_addr}, 32'h0);
        vs = 1'b0; vblank = 1'b0; ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
        chk("t4_fifo_empty_bg", bg_rgba, 32'h0);
        chk("t4_fifo_empty_und", {31'd0, underrun}, 32'd1);
        ready_pulse(32'hC000_0000);
        chk("t4_after_addr", {8'd0, ch_addr}, 32'h2);
        tick();

        // 5: two words while a read is outstanding; second is dropped
        dl_byte(25'h10, 8'h33);
        dl_byte(25'h11, 8'h44);
        dl_byte(25'h12, 8'h55);
        dl_byte(25'h13, 8'h66);
        chk("t5_wr_ovf", {31'd0, wr_ovf}, 32'd1);
        chk("t5_rdwait_noreq", {31'd0, ch_req}, 32'd0);
        ready_pulse(32'hC000_0001);
        chk("t5_wr_req", {31'd0, ch_req}, 32'd1);
        chk("t5_wr_rnw", {31'd0, ch_rnw}, 32'd0);
        chk("t5_wr_addr", {8'd0, ch_addr}, 32'h8);
        chk("t5_wr_din", {16'd0, ch_din}, 32'h4433);
        tick();
        ready_pulse(32'h0);
        chk("t5_rd_rnw", {31'd0, ch_rnw}, 32'd1);
        chk("t5_rd_addr", {8'd0, ch_addr}, 32'h4);

        // 6: reset while a write is outstanding
        dl_byte(25'h20, 8'h77);
        dl_byte(25'h21, 8'h88);
        ready_pulse(32'hC000_0002);
        chk("t6_wr_req", {31'd0, ch_req}, 32'd1);
        chk("t6_wr_addr", {8'd0, ch_addr}, 32'h10);
        chk("t6_wr_din", {16'd0, ch_din}, 32'h8877);
        tick();
        rst = 1'b1;
        #1;
        chk_all_zero("t6_reset");
        tick();
        rst = 1'b0;
        ready_pulse(32'h1234_5678);
        chk("t6_stray_noreq", {31'd0, ch_req}, 32'd0);
        chk("t6_stray_use", {31'd0, use_bg}, 32'd0);
        tick();
        chk("t6_idle_noreq", {31'd0, ch_req}, 32'd0);
        dl_byte(25'h40, 8'h99);
        dl_byte(25'h41, 8'hAA);
        chk("t6_new_req", {31'd0, ch_req}, 32'd1);
        chk("t6_new_rnw", {31'd0, ch_rnw}, 32'd0);
        chk("t6_new_addr", {8'd0, ch_addr}, 32'h20);
        chk("t6_new_din", {16'd0, ch_din}, 32'hAA99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
